// File: rtl/cmn_dsp_vrp_fifo.sv
// Routes one input stream to WIDTH outputs, each buffered by its own DEPTH-entry FIFO.
// Optional zero-latency bypass into an empty, ready output: define CMN_DSP_VRP_BYPASS_EN.
module cmn_dsp_vrp_fifo #(
   parameter int WIDTH     = 4,
   parameter int PLD_WIDTH = 32,
   parameter int DEPTH     = 2,
   localparam int IDX_W    = $clog2(WIDTH),
   localparam int CNT_W    = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 vld_s,
   output logic                 rdy_s,
   input  logic [PLD_WIDTH-1:0] pld_s,
   input  logic [IDX_W-1:0]     dst_s,
   output logic [WIDTH-1:0]     v_vld_m,
   input  logic [WIDTH-1:0]     v_rdy_m,
   output logic [PLD_WIDTH-1:0] v_pld_m [WIDTH],
   output logic [WIDTH-1:0]     v_full,
   output logic                 drop_err
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0]     wr_ptr  [WIDTH];
   logic [PTR_W-1:0]     rd_ptr  [WIDTH];
   logic [CNT_W-1:0]     cnt     [WIDTH];
   logic [CNT_W-1:0]     cnt_nxt [WIDTH];
   logic [PLD_WIDTH-1:0] mem     [WIDTH][DEPTH];
   logic [WIDTH-1:0]     full_q;
   logic [WIDTH-1:0]     hit;
   logic [WIDTH-1:0]     byp;
   logic [WIDTH-1:0]     push;
   logic [WIDTH-1:0]     pop;
   logic                 in_range;
   logic                 sel_full;

   // Out-of-range destinations select no FIFO, so they are always accepted (and dropped).
   always_comb begin
      in_range = 1'b0;
      sel_full = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (dst_s == IDX_W'(i)) begin
            in_range = 1'b1;
            sel_full = full_q[i];
         end
      end
   end

   assign rdy_s  = ~sel_full;
   assign v_full = full_q;

   always_comb begin
      hit  = '0;
      byp  = '0;
      push = '0;
      pop  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         hit[i] = vld_s && (dst_s == IDX_W'(i));
`ifdef CMN_DSP_VRP_BYPASS_EN
         byp[i] = hit[i] && (cnt[i] == '0) && v_rdy_m[i];
`endif
         push[i]    = hit[i] && !full_q[i] && !byp[i];
         pop[i]     = (cnt[i] != '0) && v_rdy_m[i];
         cnt_nxt[i] = cnt[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
   end

   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         v_vld_m[i] = (cnt[i] != '0) || byp[i];
         v_pld_m[i] = mem[i][rd_ptr[i]];
`ifdef CMN_DSP_VRP_BYPASS_EN
         if (byp[i]) v_pld_m[i] = pld_s;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < WIDTH; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            cnt[i]    <= '0;
         end
         full_q   <= '0;
         drop_err <= 1'b0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
            cnt[i]    <= cnt_nxt[i];
            full_q[i] <= (cnt_nxt[i] == CNT_W'(DEPTH));
         end
         drop_err <= vld_s && !in_range;
      end
   end

   // Payload storage carries no reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      for (int i = 0; i < WIDTH; i++) begin
         if (push[i]) mem[i][wr_ptr[i]] <= pld_s;
      end
   end

endmodule

// File: tb/tb_cmn_dsp_vrp_fifo.sv
// Bench for cmn_dsp_vrp_fifo: directed scenarios plus a randomized run against a queue model.
module tb_cmn_dsp_vrp_fifo;

   typedef logic [31:0] q_t [$];

   logic        clk = 1'b0;
   logic        rst_n;
   logic        vld, rdy;
   logic [31:0] pld;
   logic [1:0]  dst;
   logic [3:0]  vld_m, rdy_m, full;
   logic [31:0] pld_m [4];
   logic        drop;

   logic        vld3, rdy3;
   logic [31:0] pld3;
   logic [1:0]  dst3;
   logic [2:0]  vld_m3, rdy_m3, full3;
   logic [31:0] pld_m3 [3];
   logic        drop3;

   int errors = 0;
   int checks = 0;
   q_t mq [4];

   always #5 clk = ~clk;

   cmn_dsp_vrp_fifo #(.WIDTH(4), .PLD_WIDTH(32), .DEPTH(2)) dut4 (
      .clk(clk), .rst_n(rst_n), .vld_s(vld), .rdy_s(rdy), .pld_s(pld), .dst_s(dst),
      .v_vld_m(vld_m), .v_rdy_m(rdy_m), .v_pld_m(pld_m), .v_full(full), .drop_err(drop));

   cmn_dsp_vrp_fifo #(.WIDTH(3), .PLD_WIDTH(32), .DEPTH(2)) dut3 (
      .clk(clk), .rst_n(rst_n), .vld_s(vld3), .rdy_s(rdy3), .pld_s(pld3), .dst_s(dst3),
      .v_vld_m(vld_m3), .v_rdy_m(rdy_m3), .v_pld_m(pld_m3), .v_full(full3), .drop_err(drop3));

   task automatic do_reset();
      rst_n = 1'b0; vld = 1'b0; vld3 = 1'b0; rdy_m = '0; rdy_m3 = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; vld = 1'b0; vld3 = 1'b0; rdy_m = '0; rdy_m3 = '0;
      pld = '0; dst = '0; pld3 = '0; dst3 = '0;
      @(negedge clk);
      #1;
      checks++; if (vld_m !== 4'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0000", vld_m); end
      checks++; if (full !== 4'b0) begin errors++; $display("FAIL reset_full got=%b exp=0000", full); end
      checks++; if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop got=%b exp=0", drop); end
      checks++; if (vld_m3 !== 3'b0) begin errors++; $display("FAIL reset_vld3 got=%b exp=000", vld_m3); end
      rst_n = 1'b1;
      for (int d = 0; d < 4; d++) begin
         dst = 2'(d); dst3 = 2'(d);
         #1;
         checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy dst=%0d got=%b exp=1", d, rdy); end
         checks++; if (rdy3 !== 1'b1) begin errors++; $display("FAIL reset_rdy3 dst=%0d got=%b exp=1", d, rdy3); end
      end
      @(negedge clk);
   endtask

   task automatic test_basic();
      do_reset();
      vld = 1'b1; dst = 2'd2; pld = 32'hA1;
      #1;
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL basic_rdy got=%b exp=1", rdy); end
      @(negedge clk);
      vld = 1'b0;
      #1;
      checks++; if (vld_m !== 4'b0100) begin errors++; $display("FAIL basic_vld got=%b exp=0100", vld_m); end
      checks++; if (pld_m[2] !== 32'hA1) begin errors++; $display("FAIL basic_pld got=%h exp=a1", pld_m[2]); end
      checks++; if (full !== 4'b0) begin errors++; $display("FAIL basic_full got=%b exp=0000", full); end
      rdy_m = 4'b0100;
      @(negedge clk);
      #1;
      checks++; if (vld_m !== 4'b0) begin errors++; $display("FAIL basic_drain got=%b exp=0000", vld_m); end
      rdy_m = '0;
   endtask

   task automatic test_full();
      do_reset();
      vld = 1'b1; dst = 2'd1; pld = 32'hB1;
      #1;
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL full_beat1 got=%b exp=1", rdy); end
      @(negedge clk);
      pld = 32'hB2;
      #1;
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL full_beat2 got=%b exp=1", rdy); end
      @(negedge clk);
      pld = 32'hB3;
      #1;
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL full_beat3 got=%b exp=0", rdy); end
      checks++; if (full !== 4'b0010) begin errors++; $display("FAIL full_flag got=%b exp=0010", full); end
      rdy_m = 4'b0010;
      #1;
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL full_rdy_indep got=%b exp=0", rdy); end
      checks++; if (pld_m[1] !== 32'hB1) begin errors++; $display("FAIL full_head1 got=%h exp=b1", pld_m[1]); end
      @(negedge clk);
      #1;
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL full_accept3 got=%b exp=1", rdy); end
      checks++; if (pld_m[1] !== 32'hB2) begin errors++; $display("FAIL full_head2 got=%h exp=b2", pld_m[1]); end
      @(negedge clk);
      vld = 1'b0;
      #1;
      checks++; if (pld_m[1] !== 32'hB3) begin errors++; $display("FAIL full_head3 got=%h exp=b3", pld_m[1]); end
      checks++; if (vld_m[1] !== 1'b1) begin errors++; $display("FAIL full_vld3 got=%b exp=1", vld_m[1]); end
      @(negedge clk);
      #1;
      checks++; if (vld_m[1] !== 1'b0) begin errors++; $display("FAIL full_empty got=%b exp=0", vld_m[1]); end
      rdy_m = '0;
   endtask

   task automatic test_independent();
      do_reset();
      vld = 1'b1; dst = 2'd0; pld = 32'hA0;
      @(negedge clk);
      pld = 32'hA1;
      @(negedge clk);
      rdy_m = 4'b1000;
      for (int k = 0; k < 6; k++) begin
         dst = (k % 2 == 1) ? 2'd3 : 2'd0;
         pld = 32'h300 + 32'(k);
         #1;
         checks++; if (rdy !== (dst == 2'd3)) begin errors++; $display("FAIL indep_rdy k=%0d got=%b exp=%b", k, rdy, dst == 2'd3); end
`ifdef CMN_DSP_VRP_BYPASS_EN
         if (k % 2 == 1) begin
            checks++; if (vld_m[3] !== 1'b1 || pld_m[3] !== 32'h300 + 32'(k)) begin errors++; $display("FAIL indep_deliver k=%0d got=%b/%h", k, vld_m[3], pld_m[3]); end
         end
`else
         if (k > 0 && k % 2 == 0) begin
            checks++; if (vld_m[3] !== 1'b1 || pld_m[3] !== 32'h300 + 32'(k - 1)) begin errors++; $display("FAIL indep_deliver k=%0d got=%b/%h", k, vld_m[3], pld_m[3]); end
         end
`endif
         @(negedge clk);
      end
      vld = 1'b0;
      #1;
`ifndef CMN_DSP_VRP_BYPASS_EN
      checks++; if (vld_m[3] !== 1'b1 || pld_m[3] !== 32'h305) begin errors++; $display("FAIL indep_last got=%b/%h exp=1/305", vld_m[3], pld_m[3]); end
`endif
      checks++; if (full[0] !== 1'b1) begin errors++; $display("FAIL indep_full0 got=%b exp=1", full[0]); end
      checks++; if (pld_m[0] !== 32'hA0) begin errors++; $display("FAIL indep_head0 got=%h exp=a0", pld_m[0]); end
      rdy_m = '0;
   endtask

   task automatic test_push_pop();
      do_reset();
      vld = 1'b1; dst = 2'd2; pld = 32'h11;
      @(negedge clk);
      pld = 32'h22; rdy_m = 4'b0100;
      #1;
      checks++; if (pld_m[2] !== 32'h11) begin errors++; $display("FAIL pp_first got=%h exp=11", pld_m[2]); end
      @(negedge clk);
      vld = 1'b0; rdy_m = '0;
      #1;
      checks++; if (vld_m[2] !== 1'b1 || full[2] !== 1'b0) begin errors++; $display("FAIL pp_count got=%b/%b exp=1/0", vld_m[2], full[2]); end
      checks++; if (pld_m[2] !== 32'h22) begin errors++; $display("FAIL pp_second got=%h exp=22", pld_m[2]); end
      rdy_m = 4'b0100;
      @(negedge clk);
      #1;
      checks++; if (vld_m[2] !== 1'b0) begin errors++; $display("FAIL pp_empty got=%b exp=0", vld_m[2]); end
      rdy_m = '0;
   endtask

   task automatic test_drop();
      do_reset();
      vld3 = 1'b1; dst3 = 2'd3; pld3 = 32'hDEAD;
      #1;
      checks++; if (rdy3 !== 1'b1) begin errors++; $display("FAIL drop_rdy got=%b exp=1", rdy3); end
      checks++; if (drop3 !== 1'b0) begin errors++; $display("FAIL drop_early got=%b exp=0", drop3); end
      @(negedge clk);
      vld3 = 1'b0;
      #1;
      checks++; if (drop3 !== 1'b1) begin errors++; $display("FAIL drop_pulse got=%b exp=1", drop3); end
      checks++; if (vld_m3 !== 3'b0) begin errors++; $display("FAIL drop_vld got=%b exp=000", vld_m3); end
      @(negedge clk);
      #1;
      checks++; if (drop3 !== 1'b0) begin errors++; $display("FAIL drop_once got=%b exp=0", drop3); end
      vld3 = 1'b1; dst3 = 2'd1;
      @(negedge clk);
      vld3 = 1'b0;
      #1;
      checks++; if (drop3 !== 1'b0 || vld_m3 !== 3'b010) begin errors++; $display("FAIL drop_inrange got=%b/%b exp=0/010", drop3, vld_m3); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      vld = 1'b1;
      for (int k = 0; k < 4; k++) begin
         dst = 2'(k); pld = 32'h700 + 32'(k);
         @(negedge clk);
      end
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      checks++; if (vld_m !== 4'b0 || full !== 4'b0) begin errors++; $display("FAIL midrst got=%b/%b exp=0000/0000", vld_m, full); end
      vld = 1'b0; rst_n = 1'b1;
      @(negedge clk);
   endtask

`ifdef CMN_DSP_VRP_BYPASS_EN
   task automatic test_bypass();
      do_reset();
      rdy_m = 4'b0001; vld = 1'b1; dst = 2'd0; pld = 32'h5A;
      #1;
      checks++; if (vld_m[0] !== 1'b1 || pld_m[0] !== 32'h5A) begin errors++; $display("FAIL byp_same got=%b/%h exp=1/5a", vld_m[0], pld_m[0]); end
      @(negedge clk);
      vld = 1'b0;
      #1;
      checks++; if (vld_m[0] !== 1'b0) begin errors++; $display("FAIL byp_count got=%b exp=0", vld_m[0]); end
      rdy_m = '0;
   endtask
`endif

   task automatic test_random();
      logic [3:0]  e_vld, e_full, byp_e;
      logic        e_rdy;
      logic [31:0] e_pld;
      do_reset();
      for (int i = 0; i < 4; i++) mq[i].delete();
      for (int c = 0; c < 400; c++) begin
         vld   = ($urandom_range(0, 3) != 0);
         dst   = 2'($urandom_range(0, 3));
         pld   = $urandom;
         rdy_m = 4'($urandom_range(0, 15));
         #1;
         e_rdy = (mq[dst].size() != 2);
         for (int i = 0; i < 4; i++) begin
            byp_e[i] = 1'b0;
`ifdef CMN_DSP_VRP_BYPASS_EN
            byp_e[i] = vld && (dst == 2'(i)) && (mq[i].size() == 0) && rdy_m[i];
`endif
            e_vld[i]  = (mq[i].size() != 0) || byp_e[i];
            e_full[i] = (mq[i].size() == 2);
         end
         checks++; if (rdy !== e_rdy) begin errors++; $display("FAIL rnd_rdy c=%0d got=%b exp=%b", c, rdy, e_rdy); end
         checks++; if (vld_m !== e_vld) begin errors++; $display("FAIL rnd_vld c=%0d got=%b exp=%b", c, vld_m, e_vld); end
         checks++; if (full !== e_full) begin errors++; $display("FAIL rnd_full c=%0d got=%b exp=%b", c, full, e_full); end
         checks++; if (drop !== 1'b0) begin errors++; $display("FAIL rnd_drop c=%0d got=%b exp=0", c, drop); end
         for (int i = 0; i < 4; i++) begin
            if (e_vld[i]) begin
               e_pld = byp_e[i] ? pld : mq[i][0];
               checks++; if (pld_m[i] !== e_pld) begin errors++; $display("FAIL rnd_pld c=%0d out=%0d got=%h exp=%h", c, i, pld_m[i], e_pld); end
            end
         end
         for (int i = 0; i < 4; i++) begin
            if (mq[i].size() != 0 && rdy_m[i]) void'(mq[i].pop_front());
         end
         if (vld && e_rdy && !byp_e[dst]) mq[dst].push_back(pld);
         @(negedge clk);
      end
      vld = 1'b0; rdy_m = '0;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_full();
      test_independent();
      test_push_pop();
      test_drop();
      test_reset_mid();
`ifdef CMN_DSP_VRP_BYPASS_EN
      test_bypass();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cmn_dsp_vrp_fifo.md
CMN_DSP_VRP_FIFO -- requirements
Module: cmn_dsp_vrp_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of output ports; legal range 2..16.
REQ-002 SHALL have parameter PLD_WIDTH, default 32: payload width in bits.
REQ-003 SHALL have parameter DEPTH, default 2: entries per output FIFO; a power of two, at least 2.
REQ-004 SHALL define derived IDX_W = $clog2(WIDTH) and CNT_W = $clog2(DEPTH)+1.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous and active-low.
REQ-007 vld_s  input  1  input payload valid.
REQ-008 rdy_s  output  1  input accepted this cycle when vld_s&&rdy_s.
REQ-009 pld_s  input  PLD_WIDTH  input payload.
REQ-010 dst_s  input  IDX_W  destination output index, qualified by vld_s.
REQ-011 v_vld_m  output  [WIDTH-1:0]  per-output valid.
REQ-012 v_rdy_m  input  [WIDTH-1:0]  per-output ready.
REQ-013 v_pld_m  output  [PLD_WIDTH-1:0] x [WIDTH-1:0]  per-output payload, unpacked array.
REQ-014 v_full  output  [WIDTH-1:0]  per-output FIFO full flag.
REQ-015 drop_err  output  1  registered pulse flagging a discarded out-of-range transfer.

Function
REQ-016 SHALL route each accepted input transfer to output dst_s, preserving order per output; no ordering holds across outputs.
REQ-017 Each output SHALL own a DEPTH-entry FIFO with write pointer, read pointer and CNT_W-bit occupancy counter; pointers wrap modulo DEPTH.
REQ-018 rdy_s SHALL equal ~v_full[dst_s] when dst_s<WIDTH, and 1 otherwise.
REQ-019 rdy_s SHALL depend on no v_rdy_m bit; a full FIFO popped this cycle does not accept in the same cycle.
REQ-020 rdy_s MAY be asserted with vld_s low; vld_s SHALL NOT be required to depend on rdy_s.
REQ-021 A push on output i SHALL occur when vld_s && rdy_s && dst_s==i, subject to REQ-029.
REQ-022 v_vld_m[i] SHALL equal (count[i]!=0), subject to REQ-029.
REQ-023 v_pld_m[i] SHALL present the head entry; a pop occurs when v_vld_m[i]&&v_rdy_m[i].
REQ-024 Simultaneous push and pop on the same output SHALL leave count unchanged and advance both pointers.
REQ-025 v_full[i] SHALL equal (count[i]==DEPTH), driven from a register.
REQ-026 Minimum latency from input acceptance to v_vld_m is 1 cycle when bypass is absent.
REQ-027 dst_s>=WIDTH with vld_s high SHALL be accepted, discarded and not written, and SHALL raise drop_err for exactly 1 cycle on the next cycle.
REQ-028 Outputs SHALL operate independently; a stalled output SHALL NOT block transfers to any other output.

Configuration
REQ-029 With macro CMN_DSP_VRP_BYPASS_EN defined, when count[dst_s]==0, vld_s high and v_rdy_m[dst_s] high:
  - v_vld_m[dst_s] SHALL assert combinationally;
  - v_pld_m[dst_s] SHALL equal pld_s;
  - the transfer SHALL NOT be written and count SHALL stay 0 (0-cycle latency).
REQ-030 Without CMN_DSP_VRP_BYPASS_EN, every transfer SHALL pass through the FIFO, and no v_*_m output SHALL depend combinationally on vld_s, pld_s or dst_s.

Reset
REQ-031 With rst_n low at a clock edge, all pointers and counts SHALL go to 0, and v_vld_m, v_full and drop_err SHALL go to 0.
REQ-032 Reset asserted mid-operation SHALL discard all buffered payloads; payload storage need not be reset.
REQ-033 rdy_s SHALL be 1 in the first cycle after reset release for any dst_s.

Verification
REQ-034 WIDTH=4, DEPTH=2, no bypass: send 0xA1 to dst 2 with v_rdy_m=0 -> v_vld_m=4'b0100 next cycle, v_pld_m[2]=0xA1, v_full=0.
REQ-035 Hold v_rdy_m[1]=0 and send 3 beats to dst 1 -> beats 1-2 accepted, v_full[1]=1, rdy_s=0 on beat 3; raise v_rdy_m[1] -> drains in order, and beat 3 is accepted the cycle after the first pop.
REQ-036 Output 0 full and stalled, alternate sends to dst 0 and dst 3 -> all dst 3 beats accepted and delivered; dst 0 beats stall.
REQ-037 Count=1 on dst 2, push and pop in the same cycle -> count stays 1 and order is preserved (0x11 then 0x22).
REQ-038 WIDTH=3, dst_s=3 -> rdy_s=1, no v_vld_m change, drop_err=1 for one cycle.
REQ-039 Bypass enabled, output 0 empty and ready, send 0x5A -> v_vld_m[0]=1 and v_pld_m[0]=0x5A in the same cycle, count stays 0; rst_n low mid-burst -> all v_vld_m=0 next cycle.
